aes_key_expand_ctrl: RTL and testbench

- Sequences the single-round key-schedule datapath (`key_schedule`, one registered round step, 1-cycle latency) through all 10 AES-128 expansion rounds.
- Generates the Rcon sequence and stores round keys 0..10 in an internal bank.
- Exposes a random-access read port for the cipher round pipeline.
- Sits between the key-load interface and the `key_schedule` instance; the encryption rounds read keys from it.

---
 rtl/aes_key_expand_ctrl.sv | 166 ++++++++++++++++
 tb/tb_aes_key_expand_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_expand_ctrl: sequences an external one-round AES-128 key-schedule
// datapath through 10 rounds, stores round keys 0..10 and serves a read port.
// Optional macro: AES_KEY_CACHE_EN (skip expansion when the key is unchanged).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_key_expand_ctrl #(
  parameter int BUS_WIDTH  = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start_i,
  input  logic [BUS_WIDTH-1:0] key_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 keys_valid_o,
  output logic [BUS_WIDTH-1:0] ks_data_o,
  output logic [7:0]           ks_rcon_o,
  input  logic [BUS_WIDTH-1:0] ks_key_i,
  input  logic [3:0]           rk_addr_i,
  output logic [BUS_WIDTH-1:0] rk_data_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           round_q, round_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [BUS_WIDTH-1:0] ks_data_q, ks_data_d;
  logic [7:0]           ks_rcon_q, ks_rcon_d;
  logic [BUS_WIDTH-1:0] rk_data_q, rk_data_d;
  logic [BUS_WIDTH-1:0] bank_q [NUM_ROUNDS+1];
  logic [BUS_WIDTH-1:0] bank_d [NUM_ROUNDS+1];
  logic                 bank_we;
  logic [3:0]           bank_waddr;
  logic [BUS_WIDTH-1:0] bank_wdata;
`ifdef AES_KEY_CACHE_EN
  logic [BUS_WIDTH-1:0] tag_q, tag_d;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    ks_data_d  = ks_data_q;
    ks_rcon_d  = ks_rcon_q;
    bank_we    = 1'b0;
    bank_waddr = round_q;
    bank_wdata = ks_key_i;
`ifdef AES_KEY_CACHE_EN
    tag_d      = tag_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef AES_KEY_CACHE_EN
        // Bank already holds this key's schedule: report completion only.
        if (start_i && valid_q && (key_i == tag_q)) begin
          state_d = ST_FINISH;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end else
`endif
        if (start_i) begin
          bank_we    = 1'b1;
          bank_waddr = 4'd0;
          bank_wdata = key_i;
          ks_data_d  = key_i;
          ks_rcon_d  = 8'h01;
          round_d    = 4'd1;
          valid_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_ISSUE;
`ifdef AES_KEY_CACHE_EN
          tag_d      = key_i;
`endif
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        bank_we   = 1'b1;
        ks_data_d = ks_key_i;
        ks_rcon_d = xtime(ks_rcon_q);
        if (round_q == 4'(NUM_ROUNDS)) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bank_d = bank_q;
    if (bank_we) bank_d[bank_waddr] = bank_wdata;
  end

  // Addresses past the last round key read as zero.
  always_comb begin
    rk_data_d = '0;
    if (rk_addr_i <= 4'(NUM_ROUNDS)) rk_data_d = bank_q[rk_addr_i];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      round_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      ks_data_q <= '0;
      ks_rcon_q <= 8'h00;
      rk_data_q <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) bank_q[i] <= '0;
`ifdef AES_KEY_CACHE_EN
      tag_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      ks_data_q <= ks_data_d;
      ks_rcon_q <= ks_rcon_d;
      rk_data_q <= rk_data_d;
      bank_q    <= bank_d;
`ifdef AES_KEY_CACHE_EN
      tag_q     <= tag_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign keys_valid_o = valid_q;
  assign ks_data_o    = ks_data_q;
  assign ks_rcon_o    = ks_rcon_q;
  assign rk_data_o    = rk_data_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_ctrl: scoreboard bench with a behavioural key_schedule
// round model closing the datapath loop around the controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_key_expand_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
  localparam logic [7:0] RCON_TAB [10] =
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         busy, done, kv;
  logic [127:0] ks_data;
  logic [7:0]   ks_rcon;
  logic [127:0] ks_key = '0;
  logic [3:0]   addr = '0;
  logic [127:0] rk_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;

  int           done_exp [$];
  logic [7:0]   rcon_exp [$];
  int           rd_cyc [$];
  logic [127:0] rd_exp [$];
  logic [3:0]   rd_adr [$];
  logic [127:0] exp_bank [11];

  always #5 clk = ~clk;

  aes_key_expand_ctrl #(.BUS_WIDTH(128), .NUM_ROUNDS(10)) dut (
    .Clk          (clk),
    .Rst          (rst),
    .start_i      (start),
    .key_i        (key),
    .busy_o       (busy),
    .done_o       (done),
    .keys_valid_o (kv),
    .ks_data_o    (ks_data),
    .ks_rcon_o    (ks_rcon),
    .ks_key_i     (ks_key),
    .rk_addr_i    (addr),
    .rk_data_o    (rk_data)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ks_round(input logic [127:0] d, input logic [7:0] rc);
    logic [31:0] w0 = d[127:96];
    logic [31:0] w1 = d[95:64];
    logic [31:0] w2 = d[63:32];
    logic [31:0] w3 = d[31:0];
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Behavioural key_schedule: one registered round step.
  always @(posedge clk) ks_key <= ks_round(ks_data, ks_rcon);

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  initial begin
    logic [7:0] last_rcon = 8'h00;
    forever begin
      @(negedge clk);
      if (done) begin
        done_seen++;
        if (done_exp.size() == 0) fail("unexpected_done");
        else begin
          chk("done_cycle", 128'(done_exp.pop_front()), 128'(cyc));
          chk("valid_at_done", 128'(kv), 128'(1));
        end
      end
      if (busy && !done && ks_rcon !== last_rcon) begin
        if (rcon_exp.size() == 0) fail("unexpected_rcon");
        else chk("rcon_seq", 128'(ks_rcon), 128'(rcon_exp.pop_front()));
      end
      last_rcon = ks_rcon;
      if (rd_cyc.size() > 0 && rd_cyc[0] == cyc) begin
        void'(rd_cyc.pop_front());
        chk($sformatf("rk_read_addr%0d", rd_adr.pop_front()), rk_data, rd_exp.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expand(input logic [127:0] k);
    exp_bank[0] = k;
    for (int r = 1; r <= 10; r++) exp_bank[r] = ks_round(exp_bank[r-1], RCON_TAB[r-1]);
  endtask

  task automatic do_start(input logic [127:0] k, input int lat, input bit full);
    key   = k;
    start = 1'b1;
    done_exp.push_back(cyc + lat);
    if (full) for (int i = 0; i < 10; i++) rcon_exp.push_back(RCON_TAB[i]);
    tick();
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1));
    chk("valid_after_start", 128'(kv), 128'(full ? 0 : 1));
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n = 0;
    while (done_seen == prev && n < budget) begin
      tick();
      n++;
    end
    if (done_seen == prev) fail("done_timeout");
    tick();
  endtask

  task automatic rd(input logic [3:0] a, input logic [127:0] req);
    addr = a;
    rd_cyc.push_back(cyc + 1);
    rd_exp.push_back(req);
    rd_adr.push_back(a);
    tick();
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  initial begin
    int prev;

    repeat (3) tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(kv), 128'(0));
    chk("rst_ks_data", ks_data, '0);
    chk("rst_ks_rcon", 128'(ks_rcon), 128'(0));
    chk("rst_rk_data", rk_data, '0);
    rst = 1'b0;
    tick();

    // FIPS-197 key, full expansion.
    expand(FIPS_KEY);
    prev = done_seen;
    do_start(FIPS_KEY, 21, 1'b1);
    wait_done(prev, 40);
    chk("valid_after_done", 128'(kv), 128'(1));
    rd(4'd0, FIPS_KEY);
    rd(4'd1, FIPS_RK1);
    rd(4'd10, FIPS_RK10);
    rd(4'd11, '0);
    rd(4'd15, '0);
    for (int a = 2; a <= 9; a++) rd(4'(a), exp_bank[a]);
    drain();

    // All-zero key with stray starts at cycles 5 and 12.
    expand('0);
    prev = done_seen;
    do_start('0, 21, 1'b1);
    repeat (3) tick();
    key = FIPS_KEY;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    key = '0;
    wait_done(prev, 40);
    rd(4'd0, '0);
    rd(4'd1, ZERO_RK1);
    rd(4'd10, ZERO_RK10);
    for (int a = 2; a <= 9; a++) rd(4'(a), exp_bank[a]);
    drain();

    // Reset in the middle of an expansion.
    do_start(FIPS_KEY, 21, 1'b1);
    repeat (8) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_valid", 128'(kv), 128'(0));
    chk("midrst_rcon", 128'(ks_rcon), 128'(0));
    chk("midrst_rk_data", rk_data, '0);
    done_exp.delete();
    rcon_exp.delete();
    tick();
    rst = 1'b0;
    tick();
    for (int a = 0; a <= 10; a++) rd(4'(a), '0);
    drain();

    expand(FIPS_KEY);
    prev = done_seen;
    do_start(FIPS_KEY, 21, 1'b1);
    wait_done(prev, 40);
    rd(4'd10, FIPS_RK10);
    rd(4'd0, FIPS_KEY);
    drain();

`ifdef AES_KEY_CACHE_EN
    prev = done_seen;
    do_start(FIPS_KEY, 1, 1'b0);
    wait_done(prev, 10);
    chk("cache_valid_kept", 128'(kv), 128'(1));
    rd(4'd10, FIPS_RK10);
    drain();
    prev = done_seen;
    do_start('0, 21, 1'b1);
    wait_done(prev, 40);
    rd(4'd10, ZERO_RK10);
    drain();
`endif

    chk("done_queue_empty", 128'(done_exp.size()), 128'(0));
    chk("rcon_queue_empty", 128'(rcon_exp.size()), 128'(0));
    chk("read_queue_empty", 128'(rd_cyc.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule

`default_nettype wire
